digit_serial_mult: RTL and testbench
====================================

// Module: digit_serial_mult
// PURPOSE
//  Self-sequenced digit-serial multiplier; supersedes externally-controlled P=2 sequential multiplier.
//  Any digit width P; runtime operand size and signedness; internal FSM; valid/ready on both sides.
//  Consumes one PxP digit product per cycle in column order; returns the full 2N-bit product.
//  Sits between operand fetch and writeback in the bit-serial compute datapath.
// PARAMETERS
//  P          2   digit width in bits (>=1)
//  MAX_WIDTH  16  max operand width in bits; must be a multiple of P; D_MAX = MAX_WIDTH/P
// PORTS
//  clk         in   1              clock, rising edge
//  rst_n       in   1              asynchronous active-low reset
//  in_valid    in   1              operands valid
//  in_ready    out  1              block can accept operands
//  a           in   MAX_WIDTH      multiplier; only low N = D*P bits used
//  b           in   MAX_WIDTH      multiplicand; only low N bits used
//  num_digits  in   $clog2(D_MAX)+1  D = operand size in digits
//  is_signed   in   1              1: two's-complement operands; 0: unsigned
//  abort       in   1              synchronous cancel of the operation in flight
//  out_valid   out  1              product valid
//  out_ready   in   1              consumer accepts product
//  product     out  2*MAX_WIDTH    result, sign/zero-extended from 2N bits
//  busy        out  1              high in MULT or DONE
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, in_ready=1, out_valid=0, busy=0, product=0, accumulator=0.
//  D decode: num_digits==0 or >D_MAX -> D=D_MAX; latched at accept with a, b, is_signed.
//  FSM IDLE -> MULT on in_valid&in_ready; MULT -> DONE after the last pair; DONE -> IDLE on out_ready.
//  in_ready = (state==IDLE); out_valid = (state==DONE); product held stable while out_valid&!out_ready.
//  Schedule: columns k=0..2D-2; in column k, i from max(0,k-D+1) to min(k,D-1), j=k-i; one pair/cycle.
//  Digit product a_i*b_j: digit D-1 of an operand is signed iff is_signed, all other digits unsigned.
//  Digit product sign-extends into a signed accumulator, ACC_W = 2P+$clog2(D_MAX)+1 bits.
//  End of column k: result digit k <= acc[P-1:0]; acc <= acc>>>P (arithmetic shift).
//  End of column 2D-2: result digit 2D-1 <= remaining acc[P-1:0].
//  Latency: D*D MULT cycles; out_valid visible after the D*D-th edge following the accepting edge.
//  D=1 is legal: a single MULT cycle.
//  Extension: bits [2*MAX_WIDTH-1:2N] = product[2N-1] if is_signed, else 0.
//  abort in MULT: next edge -> IDLE, no out_valid, product keeps its previous value.
//  abort in DONE: behaves as out_ready. abort in IDLE: ignored, and in_valid is still accepted.
//  No back-to-back overlap: the next accept is earliest the cycle after the DONE->IDLE edge.
//  Operand inputs are ignored while not in IDLE.
// TESTING
//  P=2,MAX_WIDTH=16: D=2, unsigned, a=0xB, b=0xD -> out_valid after 4 cycles, product=0x0000008F.
//  D=2, signed, a=0xF(-1), b=0x3 -> product=0xFFFFFFFD; same with is_signed=0 -> 0x0000002D.
//  D=8 signed, a=0x8000, b=0x8000 -> product=0x40000000 after 64 cycles.
//    D=8 unsigned, a=b=0xFFFF -> product=0xFFFE0001.
//  num_digits=0 and num_digits=9 both run D=8 (64 cycles).
//    D=1 unsigned, a=0x3, b=0x3 -> 0x9 after 1 cycle.
//  Hold out_ready=0 for 10 cycles in DONE -> product stable and in_ready=0 throughout.
//    Then out_ready=1 -> IDLE, and the next accept is on the following cycle.
//  abort at MULT cycle 3 of D=4 -> IDLE next cycle, no out_valid.
//    Mid-MULT rst_n pulse -> all outputs at reset values immediately; new op then completes correctly.

Source files
------------

// File: rtl/digit_serial_mult.sv
// Self-sequenced digit-serial multiplier: one PxP digit product per cycle,
// column-ordered, with runtime operand size and signedness.
module digit_serial_mult #(
  parameter int P         = 2,
  parameter int MAX_WIDTH = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [MAX_WIDTH-1:0]           a,
  input  logic [MAX_WIDTH-1:0]           b,
  input  logic [$clog2(MAX_WIDTH/P):0]   num_digits,
  input  logic                           is_signed,
  input  logic                           abort,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [2*MAX_WIDTH-1:0]         product,
  output logic                           busy
);
  localparam int D_MAX = MAX_WIDTH / P;
  localparam int DW    = $clog2(D_MAX) + 1;
  localparam int KW    = $clog2(2 * D_MAX) + 1;
  localparam int ACC_W = 2 * P + $clog2(D_MAX) + 1;
  localparam int PW    = 2 * MAX_WIDTH;
  localparam int MW    = 2 * P + 2;

  typedef enum logic [1:0] {IDLE, MULT, DONE} state_t;
  state_t state, state_nx;

  logic [MAX_WIDTH-1:0]    a_r, b_r;
  logic                    sgn_r;
  logic [DW-1:0]           d_r, d_in;
  logic [KW-1:0]           k, i, j;
  logic [KW-1:0]           dm1, i_end, kn, i_start;
  logic                    col_end, last;
  logic [P-1:0]            a_dig, b_dig;
  logic signed [P:0]       a_ext, b_ext;
  logic signed [MW-1:0]    prod;
  logic signed [ACC_W-1:0] prod_x, acc, acc_sum, acc_sh;
  logic [PW-1:0]           res, fin, ext;

  assign d_in = (num_digits == '0 || num_digits > DW'(D_MAX))
              ? DW'(D_MAX) : num_digits;

  // Column bookkeeping: i walks the pairs of column k, j is implied
  assign dm1     = KW'(d_r) - KW'(1);
  assign j       = k - i;
  assign i_end   = (k < dm1) ? k : dm1;
  assign col_end = (i == i_end);
  assign last    = col_end && (k == (dm1 << 1));
  assign kn      = k + KW'(1);
  assign i_start = (kn > dm1) ? kn - dm1 : '0;

  // Only the top digit of a signed operand carries a sign
  assign a_dig  = a_r[int'(i) * P +: P];
  assign b_dig  = b_r[int'(j) * P +: P];
  assign a_ext  = {sgn_r && (i == dm1) && a_dig[P-1], a_dig};
  assign b_ext  = {sgn_r && (j == dm1) && b_dig[P-1], b_dig};
  assign prod   = MW'(a_ext) * MW'(b_ext);
  assign prod_x = ACC_W'(prod);
  assign acc_sum = acc + prod_x;
  assign acc_sh  = acc_sum >>> P;

  always_comb begin
    int n2;
    fin = res;
    fin[int'(k) * P +: P]         = acc_sum[P-1:0];
    fin[(int'(k) + 1) * P +: P]   = acc_sh[P-1:0];
    n2  = 2 * P * int'(d_r);
    ext = '0;
    for (int bt = 0; bt < PW; bt++)
      ext[bt] = (bt < n2) ? fin[bt] : (sgn_r & fin[n2-1]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (in_valid)              state_nx = MULT;
      MULT: if (abort)                 state_nx = IDLE;
            else if (last)             state_nx = DONE;
      DONE: if (out_ready || abort)    state_nx = IDLE;
      default:                         state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state == MULT) || (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r     <= '0;
      b_r     <= '0;
      sgn_r   <= 1'b0;
      d_r     <= DW'(1);
      k       <= '0;
      i       <= '0;
      acc     <= '0;
      res     <= '0;
      product <= '0;
    end else if (state == IDLE && in_valid) begin
      a_r   <= a;
      b_r   <= b;
      sgn_r <= is_signed;
      d_r   <= d_in;
      k     <= '0;
      i     <= '0;
      acc   <= '0;
      res   <= '0;
    end else if (state == MULT && !abort) begin
      if (col_end) begin
        res[int'(k) * P +: P] <= acc_sum[P-1:0];
        acc <= acc_sh;
        k   <= kn;
        i   <= i_start;
      end else begin
        acc <= acc_sum;
        i   <= i + KW'(1);
      end
      if (last) product <= ext;
    end
  end
endmodule

// File: tb/tb_digit_serial_mult.sv
// Directed bench for digit_serial_mult at P=2, MAX_WIDTH=16.
// Vector table plus hand-built hold, abort and reset sequences.
module tb_digit_serial_mult;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic [3:0]  num_digits = '0;
  logic        is_signed = 1'b0;
  logic        abort = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] product;
  logic        busy;

  int total = 0;
  int bad   = 0;

  digit_serial_mult #(.P(2), .MAX_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .num_digits(num_digits),
    .is_signed(is_signed), .abort(abort),
    .out_valid(out_valid), .out_ready(out_ready),
    .product(product), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  nd;
    logic        sg;
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] exp;
    int          cyc;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string nm, input logic [31:0] got,
                       input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask

  task automatic start(input logic [3:0] nd, input logic sg,
                       input logic [15:0] va, input logic [15:0] vb);
    @(negedge clk);
    in_valid   = 1'b1;
    num_digits = nd;
    is_signed  = sg;
    a          = va;
    b          = vb;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a        = 16'hA5A5;
    b        = 16'h5A5A;
  endtask

  task automatic wait_done(output int cnt);
    cnt = 0;
    while (!out_valid && cnt < 200) begin
      @(posedge clk);
      #1;
      cnt++;
    end
  endtask

  task automatic release_out();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    int cnt;
    logic [31:0] prev;

    vecs[0]  = '{4'd2, 1'b0, 16'h000B, 16'h000D, 32'h0000008F, 4};
    vecs[1]  = '{4'd2, 1'b1, 16'h000F, 16'h0003, 32'hFFFFFFFD, 4};
    vecs[2]  = '{4'd2, 1'b0, 16'h000F, 16'h0003, 32'h0000002D, 4};
    vecs[3]  = '{4'd8, 1'b1, 16'h8000, 16'h8000, 32'h40000000, 64};
    vecs[4]  = '{4'd8, 1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 64};
    vecs[5]  = '{4'd0, 1'b0, 16'h1234, 16'h0010, 32'h00012340, 64};
    vecs[6]  = '{4'd9, 1'b0, 16'h1234, 16'h0010, 32'h00012340, 64};
    vecs[7]  = '{4'd1, 1'b0, 16'h0003, 16'h0003, 32'h00000009, 1};
    vecs[8]  = '{4'd4, 1'b1, 16'h0080, 16'h007F, 32'hFFFFC080, 16};
    vecs[9]  = '{4'd2, 1'b0, 16'hFF0B, 16'hAB0D, 32'h0000008F, 4};
    vecs[10] = '{4'd1, 1'b1, 16'h0002, 16'h0003, 32'h00000002, 1};

    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_product", product, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[n]) begin
      start(vecs[n].nd, vecs[n].sg, vecs[n].a, vecs[n].b);
      check($sformatf("v%0d_busy", n), 32'(busy), 32'd1);
      wait_done(cnt);
      check($sformatf("v%0d_latency", n), 32'(cnt), 32'(vecs[n].cyc));
      check($sformatf("v%0d_product", n), product, vecs[n].exp);
      release_out();
      check($sformatf("v%0d_idle", n), 32'(in_ready), 32'd1);
    end

    // Back-pressure hold in DONE, then immediate re-accept
    start(4'd2, 1'b0, 16'h000B, 16'h000D);
    wait_done(cnt);
    check("hold_latency", 32'(cnt), 32'd4);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("hold%0d_product", c), product, 32'h0000008F);
      check($sformatf("hold%0d_in_ready", c), 32'(in_ready), 32'd0);
    end
    release_out();
    check("hold_rel_in_ready", 32'(in_ready), 32'd1);
    check("hold_rel_out_valid", 32'(out_valid), 32'd0);
    in_valid   = 1'b1;
    num_digits = 4'd2;
    is_signed  = 1'b0;
    a          = 16'h000F;
    b          = 16'h0003;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("reaccept_busy", 32'(busy), 32'd1);
    wait_done(cnt);
    check("reaccept_product", product, 32'h0000002D);
    release_out();
    prev = product;

    // Abort during MULT cycle 3 of a D=4 operation
    start(4'd4, 1'b0, 16'h00FF, 16'h00FF);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_product", product, prev);
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (out_valid) break;
    end
    check("abort_no_out_valid", 32'(out_valid), 32'd0);

    // Abort in DONE acts as out_ready
    start(4'd1, 1'b0, 16'h0002, 16'h0003);
    wait_done(cnt);
    check("abdone_product", product, 32'h00000006);
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    check("abdone_in_ready", 32'(in_ready), 32'd1);

    // Asynchronous reset in the middle of MULT
    start(4'd8, 1'b0, 16'hFFFF, 16'h0003);
    @(posedge clk);
    #1;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_in_ready", 32'(in_ready), 32'd1);
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_product", product, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Abort asserted in IDLE must not block the accept
    @(negedge clk);
    in_valid   = 1'b1;
    abort      = 1'b1;
    num_digits = 4'd8;
    is_signed  = 1'b1;
    a          = 16'hFFFF;
    b          = 16'h0003;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    abort    = 1'b0;
    check("idle_abort_busy", 32'(busy), 32'd1);
    wait_done(cnt);
    check("post_rst_latency", 32'(cnt), 32'd64);
    check("post_rst_product", product, 32'hFFFFFFFD);
    release_out();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
